ftsd_scan: RTL and testbench



---
 rtl/ftsd_scan.sv | 186 ++++++++++++++++++
 tb/tb_ftsd_scan.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ftsd_scan.sv
// Multi-digit 14-segment scan driver with frame-synchronous double-buffered loading,
// per-digit blanking and leading-zero suppression. Optional blinking via `FTSD_BLINK_EN.
`ifndef FTSD_BIT_WIDTH
`define FTSD_BIT_WIDTH 15
`define FTSD_ZERO  15'h7FC0
`define FTSD_ONE   15'h7FF9
`define FTSD_TWO   15'h7FA4
`define FTSD_THREE 15'h7FB0
`define FTSD_FOUR  15'h7F99
`define FTSD_FIVE  15'h7F92
`define FTSD_SIX   15'h7F82
`define FTSD_SEVEN 15'h7FF8
`define FTSD_EIGHT 15'h7F80
`define FTSD_NINE  15'h7F90
`define FTSD_A     15'h7F88
`define FTSD_B     15'h7F83
`define FTSD_C     15'h7FC6
`define FTSD_D     15'h7FA1
`define FTSD_E     15'h7F86
`define FTSD_F     15'h7F8E
`endif

module ftsd_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DIV_WIDTH = 16,
    parameter logic [`FTSD_BIT_WIDTH-1:0] BLANK_PATTERN = 15'h7FFF
`ifdef FTSD_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [4*NUM_DIGITS-1:0]     in_data,
    input  logic                        load,
    input  logic [NUM_DIGITS-1:0]       blank_mask,
`ifdef FTSD_BLINK_EN
    input  logic [NUM_DIGITS-1:0]       blink_mask,
`endif
    input  logic                        lz_blank_en,
    output logic [NUM_DIGITS-1:0]       ftsd_ctl,
    output logic [`FTSD_BIT_WIDTH-1:0]  display,
    output logic                        frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [DIV_WIDTH-1:0]       count;
    logic [IDX_W-1:0]           idx;
    logic                       started;
    logic [4*NUM_DIGITS-1:0]    holding;
    logic [4*NUM_DIGITS-1:0]    active;
    logic                       pending;

    logic                       tick;
    logic                       last_digit;
    logic                       boundary;
    logic [IDX_W-1:0]           next_idx;
    logic [4*NUM_DIGITS-1:0]    next_active;
    logic [NUM_DIGITS-1:0]      lz_mask;
    logic [NUM_DIGITS-1:0]      next_ctl;
    logic [3:0]                 next_nibble;
    logic                       next_blank;
    logic [`FTSD_BIT_WIDTH-1:0] next_seg;

`ifdef FTSD_BLINK_EN
    logic [15:0]                frame_cnt;
    logic                       blink_phase;
`endif

    function automatic logic [`FTSD_BIT_WIDTH-1:0] decode_nibble(input logic [3:0] nib);
        case (nib)
            4'h0: decode_nibble = `FTSD_ZERO;
            4'h1: decode_nibble = `FTSD_ONE;
            4'h2: decode_nibble = `FTSD_TWO;
            4'h3: decode_nibble = `FTSD_THREE;
            4'h4: decode_nibble = `FTSD_FOUR;
            4'h5: decode_nibble = `FTSD_FIVE;
            4'h6: decode_nibble = `FTSD_SIX;
            4'h7: decode_nibble = `FTSD_SEVEN;
            4'h8: decode_nibble = `FTSD_EIGHT;
            4'h9: decode_nibble = `FTSD_NINE;
            4'hA: decode_nibble = `FTSD_A;
            4'hB: decode_nibble = `FTSD_B;
            4'hC: decode_nibble = `FTSD_C;
            4'hD: decode_nibble = `FTSD_D;
            4'hE: decode_nibble = `FTSD_E;
            default: decode_nibble = `FTSD_F;
        endcase
    endfunction

    assign tick       = (count == DIV_WIDTH'(SCAN_DIV - 1));
    assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
    // The very first tick after reset only starts the scan; it is not a frame wrap.
    assign boundary   = tick && last_digit && started;
    assign next_idx   = (!started || last_digit) ? '0 : idx + 1'b1;

    // New frame data must already be visible to the digit-0 word registered at the wrap.
    always_comb begin
        next_active = active;
        if (boundary) begin
            if (load)
                next_active = in_data;
            else if (pending)
                next_active = holding;
        end
    end

    always_comb begin
        logic all_zero;
        all_zero    = 1'b1;
        lz_mask     = '0;
        next_ctl    = '1;
        next_nibble = 4'h0;
        next_blank  = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            all_zero   = all_zero && (next_active[4*k +: 4] == 4'h0);
            lz_mask[k] = all_zero;
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k == int'(next_idx)) begin
                next_ctl[k] = 1'b0;
                next_nibble = next_active[4*k +: 4];
                next_blank  = blank_mask[k]
`ifdef FTSD_BLINK_EN
                              || (blink_phase && blink_mask[k])
`endif
                              || (lz_blank_en && lz_mask[k]);
            end
        end
        next_seg = next_blank ? BLANK_PATTERN : decode_nibble(next_nibble);
    end

    // Prescaler, scan index, double buffer and registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            idx        <= '0;
            started    <= 1'b0;
            holding    <= '0;
            active     <= '0;
            pending    <= 1'b0;
            ftsd_ctl   <= '1;
            display    <= BLANK_PATTERN;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            count      <= tick ? '0 : count + 1'b1;
            if (boundary) begin
                active  <= next_active;
                pending <= 1'b0;
                if (load)
                    holding <= in_data;
            end else if (load) begin
                holding <= in_data;
                pending <= 1'b1;
            end
            if (tick) begin
                started    <= 1'b1;
                idx        <= next_idx;
                ftsd_ctl   <= next_ctl;
                display    <= next_seg;
                frame_done <= boundary;
            end
        end
    end

`ifdef FTSD_BLINK_EN
    // Blink phase flips once every BLINK_FRAMES completed frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (boundary) begin
            if (frame_cnt == 16'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ftsd_scan.sv
// Directed self-checking bench for ftsd_scan: a SCAN_DIV=4 instance for framing, buffering,
// blanking and reset, plus a SCAN_DIV=1 instance for the load-on-boundary case.
module tb_ftsd_scan;

    localparam logic [14:0] BLANK = 15'h7FFF;

    logic [14:0] pat [16] = '{
        15'h7FC0, 15'h7FF9, 15'h7FA4, 15'h7FB0, 15'h7F99, 15'h7F92, 15'h7F82, 15'h7FF8,
        15'h7F80, 15'h7F90, 15'h7F88, 15'h7F83, 15'h7FC6, 15'h7FA1, 15'h7F86, 15'h7F8E
    };

    logic        clk = 1'b0;
    logic        rst, load, lz_blank_en, frame_done;
    logic [15:0] in_data;
    logic [3:0]  blank_mask, ftsd_ctl;
    logic [14:0] display;

    logic        rst1, load1, frame_done1;
    logic [15:0] in_data1;
    logic [3:0]  blank_mask1, ftsd_ctl1;
    logic [14:0] display1;
    logic        lz1;

`ifdef FTSD_BLINK_EN
    logic [3:0]  blink_zero = 4'b0000;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ftsd_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .DIV_WIDTH(16), .BLANK_PATTERN(15'h7FFF)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .load(load), .blank_mask(blank_mask),
`ifdef FTSD_BLINK_EN
        .blink_mask(blink_zero),
`endif
        .lz_blank_en(lz_blank_en), .ftsd_ctl(ftsd_ctl), .display(display), .frame_done(frame_done)
    );

    ftsd_scan #(.NUM_DIGITS(4), .SCAN_DIV(1), .DIV_WIDTH(16), .BLANK_PATTERN(15'h7FFF)) dut1 (
        .clk(clk), .rst(rst1), .in_data(in_data1), .load(load1), .blank_mask(blank_mask1),
`ifdef FTSD_BLINK_EN
        .blink_mask(blink_zero),
`endif
        .lz_blank_en(lz1), .ftsd_ctl(ftsd_ctl1), .display(display1), .frame_done(frame_done1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic stepClocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] d);
        in_data = d;
        load    = 1'b1;
        @(posedge clk);
        #1;
        load    = 1'b0;
    endtask

    // Called one step after the edge that enables digit 0; returns at the next frame's digit 0.
    task automatic runFrame(input logic [15:0] exp_data, input logic [3:0] blanks, input logic exp_fd,
                            input int n_loads, input logic [15:0] ld0, input logic [15:0] ld1);
        checkOutput("frame_done_start", frame_done, exp_fd);
        for (int k = 0; k < 4; k++) begin
            logic [3:0]  ctl_exp;
            logic [14:0] seg_exp;
            int          rem;
            ctl_exp = ~(4'b0001 << k);
            seg_exp = blanks[k] ? BLANK : pat[exp_data[4*k +: 4]];
            checkOutput($sformatf("ctl_d%0d", k), ftsd_ctl, ctl_exp);
            checkOutput($sformatf("display_d%0d", k), display, seg_exp);
            rem = 4;
            if (k == 0) begin
                for (int i = 0; i < n_loads; i++) begin
                    applyStimulus(i == 0 ? ld0 : ld1);
                    rem--;
                end
            end
            stepClocks(rem - 1);
            checkOutput($sformatf("ctl_hold_d%0d", k), ftsd_ctl, ctl_exp);
            checkOutput("frame_done_mid", frame_done, 1'b0);
            stepClocks(1);
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; in_data = '0; blank_mask = '0; lz_blank_en = 1'b0;
        rst1 = 1'b1; load1 = 1'b0; in_data1 = '0; blank_mask1 = '0; lz1 = 1'b0;
        stepClocks(2);
        checkOutput("rst_ctl", ftsd_ctl, 4'hF);
        checkOutput("rst_display", display, BLANK);
        checkOutput("rst_frame_done", frame_done, 1'b0);
        checkOutput("rst1_ctl", ftsd_ctl1, 4'hF);
        checkOutput("rst1_display", display1, BLANK);

        // Load during the first frame only becomes visible from the second frame.
        rst = 1'b0;
        applyStimulus(16'h12AF);
        stepClocks(3);
        runFrame(16'h0000, 4'b0000, 1'b0, 0, '0, '0);
        runFrame(16'h12AF, 4'b0000, 1'b1, 0, '0, '0);
        runFrame(16'h12AF, 4'b0000, 1'b1, 2, 16'h3333, 16'h4444);
        lz_blank_en = 1'b1;
        runFrame(16'h4444, 4'b0000, 1'b1, 1, 16'h0070, '0);
        runFrame(16'h0070, 4'b1100, 1'b1, 1, 16'h0000, '0);
        runFrame(16'h0000, 4'b1110, 1'b1, 1, 16'h1234, '0);
        blank_mask = 4'b0001;
        runFrame(16'h1234, 4'b0000, 1'b1, 0, '0, '0);
        runFrame(16'h1234, 4'b0001, 1'b1, 0, '0, '0);

        // Asynchronous reset while digit 2 is enabled, checked before any further edge.
        stepClocks(8);
        checkOutput("pre_rst_ctl", ftsd_ctl, 4'b1011);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_ctl", ftsd_ctl, 4'hF);
        checkOutput("async_rst_display", display, BLANK);
        checkOutput("async_rst_frame_done", frame_done, 1'b0);
        stepClocks(2);
        blank_mask = '0;
        lz_blank_en = 1'b0;
        rst = 1'b0;
        stepClocks(4);
        runFrame(16'h0000, 4'b0000, 1'b0, 0, '0, '0);

        // SCAN_DIV=1: load coincides with the boundary edge.
        rst1 = 1'b0;
        stepClocks(1);
        checkOutput("div1_first_ctl", ftsd_ctl1, 4'b1110);
        checkOutput("div1_first_display", display1, pat[0]);
        stepClocks(3);
        checkOutput("div1_d3_ctl", ftsd_ctl1, 4'b0111);
        checkOutput("div1_d3_frame_done", frame_done1, 1'b0);
        in_data1 = 16'h5678;
        load1 = 1'b1;
        stepClocks(1);
        load1 = 1'b0;
        checkOutput("div1_wrap_frame_done", frame_done1, 1'b1);
        checkOutput("div1_wrap_ctl", ftsd_ctl1, 4'b1110);
        checkOutput("div1_wrap_display", display1, pat[8]);
        checkOutput("div1_pending", dut1.pending, 1'b0);
        stepClocks(1);
        checkOutput("div1_d1_display", display1, pat[7]);
        checkOutput("div1_d1_frame_done", frame_done1, 1'b0);
        stepClocks(2);
        checkOutput("div1_d3_display", display1, pat[5]);
        stepClocks(1);
        checkOutput("div1_wrap2_frame_done", frame_done1, 1'b1);
        checkOutput("div1_wrap2_display", display1, pat[8]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
